// File: rtl/rv32imc_types.sv
// Shared RV32IMC front-end types: instruction-queue entry layout and constants.
package rv32imc_types;

  localparam int unsigned XLEN = 32;

  // Canonical NOP (addi x0, x0, 0) presented whenever no instruction is valid.
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IQ_EMPTY   = 2'd0,
    IQ_PENDING = 2'd1,
    IQ_READY   = 2'd2
  } iq_state_e;

  typedef struct packed {
    iq_state_e       state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: tracks in-order imem reads,
// kills responses belonging to a flushed stream, and bypasses a response
// straight to decode when it answers the head entry.
module inst_queue
  import rv32imc_types::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        id_stall,
  input  logic        i_fetch_issue,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_next,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        o_fetch_ok,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_next,
  output logic        o_empty,
  output logic        o_full,
  output logic        o_imem_stall
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  iq_entry_t     entries [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] pending_cnt;
  logic [CW-1:0] kill_cnt;

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] fill_idx;
  logic [PW-1:0] occupancy;
  logic [CW:0]   outstanding;
  iq_entry_t     head;
  logic          empty;
  logic          full;
  logic          kill_zero;
  logic          fill;
  logic          kill_resp;
  logic          head_pending;
  logic          head_ready;
  logic          bypass;
  logic          pop;

  // Pending entries are always the youngest ones, so the oldest pending
  // entry sits pending_cnt slots behind the write pointer.
  assign rd_idx    = rd_ptr[IW-1:0];
  assign wr_idx    = wr_ptr[IW-1:0];
  assign fill_idx  = wr_ptr[IW-1:0] - IW'(pending_cnt);
  assign occupancy = wr_ptr - rd_ptr;
  assign empty     = (rd_ptr == wr_ptr);
  assign full      = (rd_ptr[PW-1] != wr_ptr[PW-1]) && (rd_idx == wr_idx);
  assign head      = entries[rd_idx];

  assign kill_zero    = (kill_cnt == '0);
  assign fill         = imem_resp && kill_zero;
  assign kill_resp    = imem_resp && !kill_zero;
  assign head_pending = !empty && (head.state == IQ_PENDING);
  assign head_ready   = !empty && (head.state == IQ_READY);
  assign bypass       = head_pending && fill;

  assign o_valid   = !i_flush && (head_ready || bypass);
  assign pop       = o_valid && !id_stall;
  assign o_inst    = o_valid ? (head_ready ? head.inst : imem_rdata) : NOP_INST;
  assign o_pc      = o_valid ? head.pc      : 32'h0;
  assign o_pc_next = o_valid ? head.pc_next : 32'h0;

  // Killed reads still occupy the memory pipeline, so they count against the limit.
  assign outstanding  = {1'b0, pending_cnt} + {1'b0, kill_cnt};
  assign o_fetch_ok   = (occupancy < PW'(DEPTH)) && (outstanding < (CW+1)'(MAX_OUTSTANDING));
  assign o_empty      = empty;
  assign o_full       = full;
  assign o_imem_stall = (head_pending && !imem_resp) || (empty && !kill_zero);

  // Queue storage, pointers and read-tracking counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pending_cnt <= '0;
      kill_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].state <= IQ_EMPTY;
    end else if (i_flush) begin
      // Every read still pending becomes a kill; a response this cycle retires one.
      kill_cnt <= kill_cnt + pending_cnt - CW'(imem_resp);
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].state <= IQ_EMPTY;
      if (i_fetch_issue) begin
        entries[0]  <= '{state: IQ_PENDING, pc: i_pc, pc_next: i_pc_next, inst: NOP_INST};
        wr_ptr      <= PW'(1);
        pending_cnt <= CW'(1);
      end else begin
        wr_ptr      <= '0;
        pending_cnt <= '0;
      end
    end else begin
      if (i_fetch_issue) begin
        entries[wr_idx] <= '{state: IQ_PENDING, pc: i_pc, pc_next: i_pc_next, inst: NOP_INST};
      end
      if (fill) begin
        entries[fill_idx].state <= IQ_READY;
        entries[fill_idx].inst  <= imem_rdata;
      end
      if (pop) entries[rd_idx].state <= IQ_EMPTY;
      if (kill_resp) kill_cnt <= kill_cnt - CW'(1);
      pending_cnt <= pending_cnt + CW'(i_fetch_issue) - CW'(fill);
      wr_ptr      <= wr_ptr + PW'(i_fetch_issue);
      rd_ptr      <= rd_ptr + PW'(pop);
    end
  end

  // Fetch must respect back-pressure, and every response must belong to a read.
  a_issue_allowed: assert property (@(posedge clk) disable iff (rst)
    i_fetch_issue |-> o_fetch_ok);
  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_resp |-> (pending_cnt != '0 || kill_cnt != '0));

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: expected deliveries are queued when the
// matching imem response is driven and retired when decode pops the head.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush;
  logic        id_stall;
  logic        i_fetch_issue;
  logic [31:0] i_pc;
  logic [31:0] i_pc_next;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        o_fetch_ok;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_pc_next;
  logic        o_empty;
  logic        o_full;
  logic        o_imem_stall;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  inst_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (i_flush),
    .id_stall     (id_stall),
    .i_fetch_issue(i_fetch_issue),
    .i_pc         (i_pc),
    .i_pc_next    (i_pc_next),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .o_fetch_ok   (o_fetch_ok),
    .o_valid      (o_valid),
    .o_inst       (o_inst),
    .o_pc         (o_pc),
    .o_pc_next    (o_pc_next),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_imem_stall (o_imem_stall)
  );

  always #5 clk = ~clk;

  // Retire the oldest expected delivery whenever decode accepts the head.
  always @(negedge clk) begin
    if (!rst && o_valid && !id_stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got pc=%h inst=%h, required no pop", o_pc, o_inst);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_inst !== mon_e.inst || o_pc !== mon_e.pc || o_pc_next !== mon_e.pc_next) begin
          failures++;
          $display("FAIL pop_data: got inst=%h pc=%h pc_next=%h, required inst=%h pc=%h pc_next=%h",
                   o_inst, o_pc, o_pc_next, mon_e.inst, mon_e.pc, mon_e.pc_next);
        end
      end
    end
  end

  // Drive one cycle of inputs just after the edge; return at the following negedge.
  task automatic set_in(input logic iss, input logic [31:0] pc, input logic rsp,
                        input logic [31:0] rd, input logic fl, input logic st);
    @(posedge clk);
    #1;
    i_fetch_issue = iss;
    i_pc          = pc;
    i_pc_next     = pc + 32'd4;
    imem_resp     = rsp;
    imem_rdata    = rd;
    i_flush       = fl;
    id_stall      = st;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    e.inst    = inst;
    e.pc      = pc;
    e.pc_next = pc + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_fetch_issue = 1'b0;
    imem_resp = 1'b0;
    i_flush = 1'b0;
    id_stall = 1'b0;
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", o_valid); end
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b required 1", o_empty); end
    checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b required 0", o_full); end
    checks++; if (o_imem_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b required 0", o_imem_stall); end
    checks++; if (o_fetch_ok !== 1'b1) begin failures++; $display("FAIL reset_fetch_ok: got %b required 1", o_fetch_ok); end
    checks++; if (o_inst !== 32'h13) begin failures++; $display("FAIL reset_inst: got %h required 00000013", o_inst); end
    checks++; if (o_pc !== 32'h0 || o_pc_next !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h/%h required 0/0", o_pc, o_pc_next); end
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    set_in(1, 32'h100, 0, 32'h0, 0, 0);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL bypass_pre_valid: got %b required 0", o_valid); end
    push_exp(32'h0050_0093, 32'h100);
    set_in(0, 32'h0, 1, 32'h0050_0093, 0, 0);
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid: got %b required 1", o_valid); end
    checks++; if (o_inst !== 32'h0050_0093) begin failures++; $display("FAIL bypass_inst: got %h required 00500093", o_inst); end
    checks++; if (o_pc !== 32'h100) begin failures++; $display("FAIL bypass_pc: got %h required 00000100", o_pc); end
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL bypass_empty: got %b required 1", o_empty); end
  endtask

  task automatic test_full();
    set_in(1, 32'h300, 0, 32'h0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      push_exp(32'h0010_0093 + 32'(k) * 32'h0010_0000, 32'h300 + 32'(k) * 32'd4);
      set_in(k < 3, 32'h304 + 32'(k) * 32'd4, 1, 32'h0010_0093 + 32'(k) * 32'h0010_0000, 0, 1);
    end
    set_in(0, 32'h0, 0, 32'h0, 0, 1);
    checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL full_flag: got %b required 1", o_full); end
    checks++; if (o_fetch_ok !== 1'b0) begin failures++; $display("FAIL full_fetch_ok: got %b required 0", o_fetch_ok); end
    for (int k = 0; k < 4; k++) begin
      set_in(0, 32'h0, 0, 32'h0, 0, 0);
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h300 + 32'(k) * 32'd4) begin
        failures++;
        $display("FAIL full_drain_%0d: got valid=%b pc=%h required valid=1 pc=%h", k, o_valid, o_pc, 32'h300 + 32'(k) * 32'd4);
      end
    end
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
    checks++; if (o_empty !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL full_drained: got empty=%b valid=%b required 1/0", o_empty, o_valid); end
  endtask

  task automatic test_flush_kill();
    set_in(1, 32'h400, 0, 32'h0, 0, 0);
    set_in(1, 32'h404, 0, 32'h0, 0, 0);
    set_in(0, 32'h0, 0, 32'h0, 1, 0);
    checks++; if (o_valid !== 1'b0 || o_inst !== 32'h13) begin failures++; $display("FAIL kill_flush_out: got valid=%b inst=%h required 0/00000013", o_valid, o_inst); end
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
    checks++; if (dut.kill_cnt !== 2'd2) begin failures++; $display("FAIL kill_cnt_set: got %0d required 2", dut.kill_cnt); end
    checks++; if (o_empty !== 1'b1 || o_imem_stall !== 1'b1) begin failures++; $display("FAIL kill_wait: got empty=%b stall=%b required 1/1", o_empty, o_imem_stall); end
    set_in(0, 32'h0, 1, 32'hdead_0001, 0, 0);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL kill_resp0: got valid=%b required 0", o_valid); end
    set_in(0, 32'h0, 1, 32'hdead_0002, 0, 0);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL kill_resp1: got valid=%b required 0", o_valid); end
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
    checks++; if (dut.kill_cnt !== 2'd0 || o_fetch_ok !== 1'b1) begin failures++; $display("FAIL kill_done: got kill=%0d ok=%b required 0/1", dut.kill_cnt, o_fetch_ok); end
    set_in(1, 32'h200, 0, 32'h0, 0, 0);
    push_exp(32'h13, 32'h200);
    set_in(0, 32'h0, 1, 32'h13, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h200) begin failures++; $display("FAIL kill_new_stream: got valid=%b pc=%h required 1/00000200", o_valid, o_pc); end
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_flush_same_cycle();
    set_in(1, 32'h500, 0, 32'h0, 0, 0);
    set_in(1, 32'h600, 1, 32'h1111_1111, 1, 0);
    checks++; if (o_valid !== 1'b0 || o_inst !== 32'h13) begin failures++; $display("FAIL same_flush_out: got valid=%b inst=%h required 0/00000013", o_valid, o_inst); end
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
    checks++; if (dut.kill_cnt !== 2'd0) begin failures++; $display("FAIL same_kill: got %0d required 0", dut.kill_cnt); end
    checks++; if (o_empty !== 1'b0 || o_imem_stall !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL same_pending: got empty=%b stall=%b valid=%b required 0/1/0", o_empty, o_imem_stall, o_valid); end
    push_exp(32'h2222_2222, 32'h600);
    set_in(0, 32'h0, 1, 32'h2222_2222, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h600) begin failures++; $display("FAIL same_deliver: got valid=%b pc=%h required 1/00000600", o_valid, o_pc); end
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_outstanding();
    set_in(1, 32'h700, 0, 32'h0, 0, 1);
    set_in(1, 32'h704, 0, 32'h0, 0, 1);
    set_in(0, 32'h0, 0, 32'h0, 0, 1);
    checks++; if (o_fetch_ok !== 1'b0 || o_full !== 1'b0) begin failures++; $display("FAIL out_limit: got ok=%b full=%b required 0/0", o_fetch_ok, o_full); end
    push_exp(32'h0AA0_0093, 32'h700);
    set_in(0, 32'h0, 1, 32'h0AA0_0093, 0, 1);
    set_in(0, 32'h0, 0, 32'h0, 0, 1);
    checks++; if (o_fetch_ok !== 1'b1) begin failures++; $display("FAIL out_release: got ok=%b required 1", o_fetch_ok); end
    push_exp(32'h0BB0_0093, 32'h704);
    set_in(0, 32'h0, 1, 32'h0BB0_0093, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h700) begin failures++; $display("FAIL out_pop0: got valid=%b pc=%h required 1/00000700", o_valid, o_pc); end
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h704) begin failures++; $display("FAIL out_pop1: got valid=%b pc=%h required 1/00000704", o_valid, o_pc); end
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_reset_mid();
    set_in(1, 32'h900, 0, 32'h0, 0, 1);
    set_in(1, 32'h904, 1, 32'h1, 0, 1);
    set_in(1, 32'h908, 1, 32'h2, 0, 1);
    set_in(0, 32'h0, 0, 32'h0, 0, 1);
    checks++; if (o_empty !== 1'b0) begin failures++; $display("FAIL rstmid_loaded: got empty=%b required 0", o_empty); end
    pulse_reset();
    checks++; if (o_empty !== 1'b1 || o_valid !== 1'b0 || o_fetch_ok !== 1'b1) begin failures++; $display("FAIL rstmid_a: got empty=%b valid=%b ok=%b required 1/0/1", o_empty, o_valid, o_fetch_ok); end
    set_in(1, 32'hA00, 0, 32'h0, 0, 1);
    set_in(1, 32'hA04, 0, 32'h0, 1, 1);
    set_in(0, 32'h0, 0, 32'h0, 0, 1);
    checks++; if (dut.kill_cnt !== 2'd1 || o_empty !== 1'b0) begin failures++; $display("FAIL rstmid_kill_pre: got kill=%0d empty=%b required 1/0", dut.kill_cnt, o_empty); end
    pulse_reset();
    checks++; if (dut.kill_cnt !== 2'd0 || o_empty !== 1'b1 || o_valid !== 1'b0 || o_fetch_ok !== 1'b1 || o_imem_stall !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_b: got kill=%0d empty=%b valid=%b ok=%b stall=%b required 0/1/0/1/0", dut.kill_cnt, o_empty, o_valid, o_fetch_ok, o_imem_stall);
    end
    set_in(1, 32'hB00, 0, 32'h0, 0, 0);
    push_exp(32'h0CC0_0093, 32'hB00);
    set_in(0, 32'h0, 1, 32'h0CC0_0093, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'hB00) begin failures++; $display("FAIL rstmid_after: got valid=%b pc=%h required 1/00000b00", o_valid, o_pc); end
    set_in(0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    i_flush = 1'b0;
    id_stall = 1'b0;
    i_fetch_issue = 1'b0;
    i_pc = 32'h0;
    i_pc_next = 32'h0;
    imem_rdata = 32'h0;
    imem_resp = 1'b0;
    test_reset();
    test_bypass();
    test_full();
    test_flush_kill();
    test_flush_same_cycle();
    test_outstanding();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained: got %0d entries left required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
